// File: rtl/prog_seq_pkg.sv
// Shared types for the programmable pattern sequencer: FSM states, playback
// modes and ping-pong direction encoding.
package prog_seq_pkg;

   typedef enum logic [1:0] {
      ST_PROG = 2'd0,
      ST_PLAY = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   localparam logic [1:0] MODE_LOOP     = 2'd0;
   localparam logic [1:0] MODE_ONESHOT  = 2'd1;
   localparam logic [1:0] MODE_PINGPONG = 2'd2;
   localparam logic [1:0] MODE_LOOP_ALT = 2'd3;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/prog_pattern_sequencer_edge_detect.sv
// Registered rising-edge detector: one-cycle pulse, one cycle after the
// input level goes high.
module edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic level,
   output logic rise
);

   logic prev_q, prev_d;
   logic rise_q, rise_d;

   always_comb begin
      prev_d = level;
      rise_d = level & ~prev_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         prev_q <= prev_d;
         rise_q <= rise_d;
      end
   end

   assign rise = rise_q;

endmodule

// File: rtl/prog_pattern_sequencer.sv
// Programmable LED pattern sequencer: record patterns in PROG, play them back
// in loop / one-shot / ping-pong order. Ping-pong needs `SEQ_PINGPONG_EN.
module prog_pattern_sequencer
   import prog_seq_pkg::*;
#(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned STEP_CYCLES = 50_000_000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         switch,
   input  logic                     enter,
   input  logic                     start,
   input  logic                     stop,
   input  logic                     clear,
   input  logic [1:0]               mode,
   output logic [WIDTH-1:0]         out_pattern,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     playing,
   output logic                     full
);

   localparam int unsigned IW = $clog2(DEPTH);
   localparam int unsigned CW = IW + 1;
   localparam int unsigned TW = $clog2(STEP_CYCLES);
   localparam logic [TW-1:0] TICK_MAX = TW'(STEP_CYCLES - 1);

   logic enter_rise, start_rise, stop_rise;

   edge_detect u_enter_ed (.clk(clk), .rst(rst), .level(enter), .rise(enter_rise));
   edge_detect u_start_ed (.clk(clk), .rst(rst), .level(start), .rise(start_rise));
   edge_detect u_stop_ed  (.clk(clk), .rst(rst), .level(stop),  .rise(stop_rise));

   state_e            state_q, state_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [TW-1:0]     tick_q, tick_d;
   logic [CW-1:0]     count_q, count_d;
   logic [WIDTH-1:0]  out_q, out_d;
   logic [1:0]        mode_q, mode_d;
   logic              playing_q, playing_d;
`ifdef SEQ_PINGPONG_EN
   logic              dir_q, dir_d;
`endif
   logic [WIDTH-1:0]  store_q [DEPTH];
   logic              wr_en;
   logic              go_play;
   logic              at_end;

   assign full   = (count_q == CW'(DEPTH));
   assign at_end = ({1'b0, idx_q} == (count_q - CW'(1)));

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      tick_d  = tick_q;
      count_d = count_q;
      out_d   = out_q;
      mode_d  = mode_q;
`ifdef SEQ_PINGPONG_EN
      dir_d   = dir_q;
`endif
      wr_en   = 1'b0;
      go_play = 1'b0;

      unique case (state_q)
         ST_PROG: begin
            if (clear) begin
               count_d = '0;
               out_d   = '0;
            end else if (start_rise) begin
               go_play = (count_q != '0);
            end else if (enter_rise && !full) begin
               wr_en   = 1'b1;
               count_d = count_q + CW'(1);
               out_d   = switch;
            end
         end
         ST_PLAY: begin
            if (stop_rise) begin
               state_d = ST_PROG;
            end else if (tick_q == TICK_MAX) begin
               tick_d = '0;
`ifdef SEQ_PINGPONG_EN
               if (mode_q == MODE_PINGPONG) begin
                  if (count_q == CW'(1)) begin
                     idx_d = '0;
                  end else if (dir_q == DIR_UP) begin
                     if (at_end) begin
                        dir_d = DIR_DOWN;
                        idx_d = idx_q - IW'(1);
                     end else begin
                        idx_d = idx_q + IW'(1);
                     end
                  end else if (idx_q == '0) begin
                     dir_d = DIR_UP;
                     idx_d = IW'(1);
                  end else begin
                     idx_d = idx_q - IW'(1);
                  end
               end else
`endif
               if (at_end) begin
                  // one-shot parks on the last entry; every other mode wraps
                  if (mode_q == MODE_ONESHOT) state_d = ST_HOLD;
                  else                        idx_d   = '0;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
               out_d = store_q[idx_d];
            end else begin
               tick_d = tick_q + TW'(1);
            end
         end
         ST_HOLD: begin
            if (stop_rise)       state_d = ST_PROG;
            else if (start_rise) go_play = (count_q != '0);
         end
         default: state_d = ST_PROG;
      endcase

      if (go_play) begin
         state_d = ST_PLAY;
         idx_d   = '0;
         tick_d  = '0;
         mode_d  = mode;
         out_d   = store_q[0];
`ifdef SEQ_PINGPONG_EN
         dir_d   = DIR_UP;
`endif
      end

      playing_d = (state_d == ST_PLAY);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_PROG;
         idx_q     <= '0;
         tick_q    <= '0;
         count_q   <= '0;
         out_q     <= '0;
         mode_q    <= MODE_LOOP;
         playing_q <= 1'b0;
`ifdef SEQ_PINGPONG_EN
         dir_q     <= DIR_UP;
`endif
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         tick_q    <= tick_d;
         count_q   <= count_d;
         out_q     <= out_d;
         mode_q    <= mode_d;
         playing_q <= playing_d;
`ifdef SEQ_PINGPONG_EN
         dir_q     <= dir_d;
`endif
      end
   end

   // Pattern store has no reset; contents are only meaningful below count.
   always_ff @(posedge clk) begin
      if (wr_en) store_q[count_q[IW-1:0]] <= switch;
   end

   assign out_pattern = out_q;
   assign count       = count_q;
   assign playing     = playing_q;

endmodule
